// File: rtl/sram_arbiter.sv
// Three-port arbiter for the shared 64Kx8 SRAM: req/done handshake per port,
// fixed priority p0 > p1 > p2 with aging on p1/p2, programmable read/write
// access length and a one-cycle bus turnaround after every access.
//
// state  | meaning
// IDLE   | bus released, arbitration evaluated at every edge
// ACCESS | SRAM strobes driven for RD_TICKS or WR_TICKS cycles
// TURN   | strobes released, done pulse to the owner, then back to IDLE
module sram_arbiter #(
    parameter int RD_TICKS  = 4,
    parameter int WR_TICKS  = 4,
    parameter int AGE_LIMIT = 3
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_done,
    output logic [7:0]  p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_done,
    output logic [7:0]  p1_rdata,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [15:0] p2_addr,
    input  logic [7:0]  p2_wdata,
    output logic        p2_done,
    output logic [7:0]  p2_rdata,
    output logic [15:0] sram_addrbus,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en,
    input  logic [7:0]  sram_din,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic [2:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    state_t      state;
    logic [2:0]  tick;
    logic        cur_we;
    logic [2:0]  age1;
    logic [2:0]  age2;
    logic [2:0]  done;
    logic [2:0]  win;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    assign p0_done = done[0];
    assign p1_done = done[1];
    assign p2_done = done[2];

    // Winner selection: a boosted (aged-out) requester beats fixed priority;
    // boost only counts while that port is still requesting.
    always_comb begin
        win       = 3'b000;
        sel_we    = 1'b0;
        sel_addr  = 16'h0000;
        sel_wdata = 8'h00;
        if (p1_req && age1 == 3'(AGE_LIMIT))      win = 3'b010;
        else if (p2_req && age2 == 3'(AGE_LIMIT)) win = 3'b100;
        else if (p0_req)                          win = 3'b001;
        else if (p1_req)                          win = 3'b010;
        else if (p2_req)                          win = 3'b100;
        if (win[0]) begin
            sel_we = p0_we; sel_addr = p0_addr; sel_wdata = p0_wdata;
        end else if (win[1]) begin
            sel_we = p1_we; sel_addr = p1_addr; sel_wdata = p1_wdata;
        end else if (win[2]) begin
            sel_we = p2_we; sel_addr = p2_addr; sel_wdata = p2_wdata;
        end
    end

    // Sequencer: arbitration, strobe timing, read capture and done pulse.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state        <= IDLE;
            tick         <= 3'd0;
            cur_we       <= 1'b0;
            age1         <= 3'd0;
            age2         <= 3'd0;
            done         <= 3'b000;
            grant        <= 3'b000;
            busy         <= 1'b0;
            p0_rdata     <= 8'h00;
            p1_rdata     <= 8'h00;
            p2_rdata     <= 8'h00;
            sram_addrbus <= 16'h0000;
            sram_dout    <= 8'h00;
            sram_dout_en <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_ce_n    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 3'b000;
                    if (!p1_req || win[1])            age1 <= 3'd0;
                    else if (age1 < 3'(AGE_LIMIT))    age1 <= age1 + 3'd1;
                    if (!p2_req || win[2])            age2 <= 3'd0;
                    else if (age2 < 3'(AGE_LIMIT))    age2 <= age2 + 3'd1;
                    if (|win) begin
                        state        <= ACCESS;
                        busy         <= 1'b1;
                        grant        <= win;
                        cur_we       <= sel_we;
                        sram_addrbus <= sel_addr;
                        sram_dout    <= sel_wdata;
                        tick         <= sel_we ? 3'(WR_TICKS) : 3'(RD_TICKS);
                        sram_ce_n    <= 1'b0;
                        sram_oe_n    <= sel_we;
                        sram_we_n    <= ~sel_we;
                        sram_dout_en <= sel_we;
                    end
                end
                ACCESS: begin
                    if (tick == 3'd1) begin
                        state        <= TURN;
                        done         <= grant;
                        sram_ce_n    <= 1'b1;
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                        sram_dout_en <= 1'b0;
                        if (!cur_we) begin
                            if (grant[0]) p0_rdata <= sram_din;
                            if (grant[1]) p1_rdata <= sram_din;
                            if (grant[2]) p2_rdata <= sram_din;
                        end
                    end else begin
                        tick <= tick - 3'd1;
                        // last write cycle is the data hold cycle
                        if (cur_we && tick == 3'd2) sram_we_n <= 1'b1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= 3'b000;
                    done  <= 3'b000;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: three behavioural requesters, a bench
// SRAM on the pins, and a transaction-level model predicting owner, timing,
// strobes and read data for every cycle.
module tb_sram_arbiter;

    localparam int RD   = 3;
    localparam int WR   = 5;
    localparam int AGE  = 3;
    localparam int NCYC = 4000;

    logic        clock_50;
    logic        reset_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr [3];
    logic [7:0]  wdata [3];
    logic        p0_done, p1_done, p2_done;
    logic [7:0]  p0_rdata, p1_rdata, p2_rdata;
    logic [15:0] sram_addrbus;
    logic [7:0]  sram_dout;
    logic        sram_dout_en;
    logic [7:0]  sram_din;
    logic        sram_we_n, sram_oe_n, sram_ce_n;
    logic [2:0]  grant;
    logic        busy;

    sram_arbiter #(.RD_TICKS(RD), .WR_TICKS(WR), .AGE_LIMIT(AGE)) dut (
        .clock_50(clock_50), .reset_n(reset_n),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_done(p1_done), .p1_rdata(p1_rdata),
        .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]), .p2_wdata(wdata[2]),
        .p2_done(p2_done), .p2_rdata(p2_rdata),
        .sram_addrbus(sram_addrbus), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .grant(grant), .busy(busy)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    // bench SRAM on the pins
    logic [7:0] sram_mem [0:65535];
    logic [7:0] ref_mem  [0:65535];
    assign sram_din = sram_oe_n ? 8'hEE : sram_mem[sram_addrbus];
    always @(negedge clock_50)
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addrbus] = sram_dout;

    int vectors = 0;
    int errors  = 0;
    int e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, e, obs, exp);
        end
    endtask

    // transaction-level model
    bit         act;
    bit         g_now;
    bit         rst_seen;
    int         free_at;
    int         st, cp, ct;
    bit         cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    int         age [3];
    logic [7:0] exp_rd [3];

    // requesters
    int  rstate [3];
    bit  plan_rst;

    function automatic bit rnd(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    task automatic new_req(input int p);
        we[p]    = rnd(2);
        addr[p]  = rnd(4) ? 16'($urandom) : {12'h5A3, 4'($urandom_range(0, 15))};
        wdata[p] = 8'($urandom);
    endtask

    task automatic model_step();
        int w;
        g_now    = 0;
        rst_seen = !reset_n;
        if (!reset_n) begin
            act = 0;
            free_at = e + 1;
            for (int p = 0; p < 3; p++) begin age[p] = 0; exp_rd[p] = 8'h00; end
            return;
        end
        if (act && e == st + ct && !cw) exp_rd[cp] = ref_mem[ca];
        if (e >= free_at) begin
            w = -1;
            if (req[1] && age[1] == AGE)      w = 1;
            else if (req[2] && age[2] == AGE) w = 2;
            else if (req[0])                  w = 0;
            else if (req[1])                  w = 1;
            else if (req[2])                  w = 2;
            for (int p = 1; p < 3; p++)
                age[p] = (!req[p] || p == w) ? 0 : ((age[p] < AGE) ? age[p] + 1 : AGE);
            if (w >= 0) begin
                act = 1; g_now = 1;
                cp = w; cw = we[w]; ca = addr[w]; cd = wdata[w];
                ct = cw ? WR : RD;
                st = e;
                free_at = e + ct + 2;
                if (cw) ref_mem[ca] = cd;
            end
        end
    endtask

    task automatic check_cycle();
        int k;
        bit in_acc, in_turn;
        logic [2:0] eg, ed;
        k = e - st;
        in_acc  = act && !rst_seen && k >= 0 && k < ct;
        in_turn = act && !rst_seen && k == ct;
        eg = (in_acc || in_turn) ? 3'(1 << cp) : 3'b000;
        ed = in_turn ? 3'(1 << cp) : 3'b000;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(in_acc || in_turn));
        chk("done", 32'({p2_done, p1_done, p0_done}), 32'(ed));
        chk("ce_n", 32'(sram_ce_n), 32'(!in_acc));
        chk("oe_n", 32'(sram_oe_n), 32'(!(in_acc && !cw)));
        chk("we_n", 32'(sram_we_n), 32'(!(in_acc && cw && k < ct - 1)));
        chk("dout_en", 32'(sram_dout_en), 32'(in_acc && cw));
        chk("rdata0", 32'(p0_rdata), 32'(exp_rd[0]));
        chk("rdata1", 32'(p1_rdata), 32'(exp_rd[1]));
        chk("rdata2", 32'(p2_rdata), 32'(exp_rd[2]));
        if (in_acc) begin
            chk("addrbus", 32'(sram_addrbus), 32'(ca));
            if (cw) chk("dout", 32'(sram_dout), 32'(cd));
        end
        if (rst_seen) begin
            chk("rst_addrbus", 32'(sram_addrbus), 32'h0);
            chk("rst_dout", 32'(sram_dout), 32'h0);
        end
    endtask

    task automatic drive(input int cyc);
        int req_n, keep_n, p1_n;
        if (cyc < 1500)      begin req_n = 3;  keep_n = 4; p1_n = 3;  end
        else if (cyc < 2500) begin req_n = 1;  keep_n = 1; p1_n = 20; end
        else                 begin req_n = 12; keep_n = 6; p1_n = 12; end
        plan_rst = (cyc < 2) || (cyc < 1500 && act && !rst_seen && g_now && cw && rnd(6));
        for (int p = 0; p < 3; p++) begin
            if (rst_seen) begin
                rstate[p] = 0; req[p] = 1'b0;
                continue;
            end
            case (rstate[p])
                0: if (rnd(p == 1 ? p1_n : req_n)) begin
                       req[p] = 1'b1; new_req(p); rstate[p] = 1;
                   end
                1: if (g_now && cp == p) begin
                       rstate[p] = 2;
                       new_req(p);
                       if (rnd(4)) req[p] = 1'b0;
                   end else if (rnd(40)) begin
                       req[p] = 1'b0; rstate[p] = 0;
                   end
                2: if (act && cp == p && e - st == ct) begin
                       if (req[p] && rnd(keep_n)) begin new_req(p); rstate[p] = 1; end
                       else begin req[p] = 1'b0; rstate[p] = 3; end
                   end
                default: rstate[p] = 0;
            endcase
        end
        reset_n = !plan_rst;
    endtask

    initial begin
        reset_n = 1'b0;
        req = 3'b000;
        we  = 3'b000;
        act = 0; g_now = 0; rst_seen = 1; free_at = 0; st = 0; cp = 0; ct = 0;
        cw = 0; ca = 16'h0; cd = 8'h0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = 16'h0; wdata[p] = 8'h0; age[p] = 0; exp_rd[p] = 8'h0; rstate[p] = 0;
        end
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock_50);
            e = cyc;
            model_step();
            @(negedge clock_50);
            check_cycle();
            drive(cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
